insfetch: RTL and testbench

Dual-issue instruction fetch unit that feeds the `insdec` front end of the superscalar core. It owns the fetch PC, fetches aligned instruction pairs from instruction memory over a single-outstanding request/response handshake, and buffers them in a small pair queue. Each cycle the ROB is not full, it presents one pair to the decoder. It is the consumer of the ROB's `ROB_full`, jump, branch and flush outputs: it redirects the PC and discards in-flight and buffered instructions on any of them.

---
 rtl/insfetch.sv | 172 +++++++++++++++++
 tb/tb_insfetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/insfetch.sv
// insfetch: dual-issue fetch unit; owns fetch PC, fetches aligned pairs, queues them for decode.
// Latency: request->queue takes memory latency + 1 edge; queue->outputs takes 1 edge (registered).
// Backpressure: ROB_full_i stalls pops; requests stop when queue is full; redirects flush everything.
// Ports: clk/rst (sync, active-high); imem_* single-outstanding fetch handshake;
//        ROB_full_i, jump/branch/flush redirects; instruction1/2_o, ins1/2_valid_o, PC1/2_o to decoder.
module insfetch #(
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  FQ_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_data1_i,
  input  logic [INSTR_WIDTH-1:0] imem_data2_i,
  input  logic                   ROB_full_i,
  input  logic                   jump_en_i,
  input  logic [PC_WIDTH-1:0]    jump_PC_i,
  input  logic                   branch_en_i,
  input  logic [PC_WIDTH-1:0]    branch_PC_i,
  input  logic                   flush_en_i,
  input  logic [PC_WIDTH-1:0]    flush_PC_i,
  output logic [INSTR_WIDTH-1:0] instruction1_o,
  output logic [INSTR_WIDTH-1:0] instruction2_o,
  output logic                   ins1_valid_o,
  output logic                   ins2_valid_o,
  output logic [PC_WIDTH-1:0]    PC1_o,
  output logic [PC_WIDTH-1:0]    PC2_o
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [INSTR_WIDTH-1:0] fq_i1_q [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] fq_i1_d [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] fq_i2_q [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] fq_i2_d [FQ_DEPTH];
  logic [PC_WIDTH-1:0]    fq_pc_q [FQ_DEPTH];
  logic [PC_WIDTH-1:0]    fq_pc_d [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] ins1_q, ins1_d, ins2_q, ins2_d;
  logic [PC_WIDTH-1:0]    pc1_q, pc1_d, pc2_q, pc2_d;
  logic                   vld_q, vld_d;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;
  logic                   req, push, pop;

  always_comb begin
    redirect = flush_en_i | branch_en_i | jump_en_i;
    if (flush_en_i)       target = flush_PC_i;
    else if (branch_en_i) target = branch_PC_i;
    else                  target = jump_PC_i;
    target[1:0] = 2'b00;

    req  = (state_q == S_IDLE) && !rst && !redirect && (count_q < DEPTH_C);
    // A response is only kept when it belongs to a request that no redirect has overtaken.
    push = (state_q == S_WAIT) && imem_valid_i && !redirect;
    pop  = !redirect && (count_q != '0) && !ROB_full_i;
  end

  assign imem_req_o  = req;
  assign imem_addr_o = req ? fetch_pc_q : '0;

  // Fetch FSM and fetch PC
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: if (req) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid_i)  state_d = S_IDLE;
        else if (redirect) state_d = S_DROP;
      end
      // The outstanding response is stale; swallow it before issuing anything new.
      S_DROP: if (imem_valid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (redirect)  fetch_pc_d = target;
    else if (push) fetch_pc_d = fetch_pc_q + PC_WIDTH'(8);
  end

  // Pair queue and registered output stage
  always_comb begin
    fq_i1_d  = fq_i1_q;
    fq_i2_d  = fq_i2_q;
    fq_pc_d  = fq_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ins1_d   = ins1_q;
    ins2_d   = ins2_q;
    pc1_d    = pc1_q;
    pc2_d    = pc2_q;
    vld_d    = 1'b0;

    if (push) begin
      fq_i1_d[wr_ptr_q] = imem_data1_i;
      fq_i2_d[wr_ptr_q] = imem_data2_i;
      fq_pc_d[wr_ptr_q] = fetch_pc_q;
    end

    if (pop) begin
      ins1_d = fq_i1_q[rd_ptr_q];
      ins2_d = fq_i2_q[rd_ptr_q];
      pc1_d  = fq_pc_q[rd_ptr_q];
      pc2_d  = fq_pc_q[rd_ptr_q] + PC_WIDTH'(4);
      vld_d  = 1'b1;
    end

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ins1_q     <= '0;
      ins2_q     <= '0;
      pc1_q      <= '0;
      pc2_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ins1_q     <= ins1_d;
      ins2_q     <= ins2_d;
      pc1_q      <= pc1_d;
      pc2_q      <= pc2_d;
      vld_q      <= vld_d;
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    fq_i1_q <= fq_i1_d;
    fq_i2_q <= fq_i2_d;
    fq_pc_q <= fq_pc_d;
  end

  assign instruction1_o = ins1_q;
  assign instruction2_o = ins2_q;
  assign PC1_o          = pc1_q;
  assign PC2_o          = pc2_q;
  assign ins1_valid_o   = vld_q;
  assign ins2_valid_o   = vld_q;

endmodule

// File: tb/tb_insfetch.sv
module tb_insfetch;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_data1_i, imem_data2_i;
  logic        ROB_full_i;
  logic        jump_en_i, branch_en_i, flush_en_i;
  logic [31:0] jump_PC_i, branch_PC_i, flush_PC_i;
  logic [31:0] instruction1_o, instruction2_o;
  logic        ins1_valid_o, ins2_valid_o;
  logic [31:0] PC1_o, PC2_o;

  always #5 clk = ~clk;

  insfetch #(.INSTR_WIDTH(32), .PC_WIDTH(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_data1_i(imem_data1_i), .imem_data2_i(imem_data2_i),
    .ROB_full_i(ROB_full_i),
    .jump_en_i(jump_en_i), .jump_PC_i(jump_PC_i),
    .branch_en_i(branch_en_i), .branch_PC_i(branch_PC_i),
    .flush_en_i(flush_en_i), .flush_PC_i(flush_PC_i),
    .instruction1_o(instruction1_o), .instruction2_o(instruction2_o),
    .ins1_valid_o(ins1_valid_o), .ins2_valid_o(ins2_valid_o),
    .PC1_o(PC1_o), .PC2_o(PC2_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of pair PCs awaiting decode, memory with one outstanding request.
  logic [31:0] mq[$];
  bit          outst, stale, mem_fire, stray;
  int          wait_cnt, mem_lat;
  logic [31:0] outst_addr, next_fetch;
  logic        exp_v;
  logic [31:0] exp_pc1, exp_pc2, exp_i1, exp_i2;
  logic        last_req, last_v;
  logic [31:0] last_addr, last_pc1, last_pc2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    outst = 0; stale = 0;
    exp_v = 0; exp_pc1 = 0; exp_pc2 = 0; exp_i1 = 0; exp_i2 = 0;
    next_fetch = RST_PC;
  endtask

  // One clock cycle: drive memory, check all outputs, advance the model across the edge.
  task automatic step();
    logic        redir, accept, exp_req;
    logic [31:0] tgt, p;
    mem_fire = 0;
    if (outst) begin
      wait_cnt--;
      if (wait_cnt == 0) mem_fire = 1;
    end
    if (mem_fire) begin
      imem_valid_i = 1; imem_data1_i = mem_word(outst_addr); imem_data2_i = mem_word(outst_addr + 4);
    end else if (stray && !outst) begin
      imem_valid_i = 1; imem_data1_i = $urandom; imem_data2_i = $urandom;
    end else begin
      imem_valid_i = 0; imem_data1_i = $urandom; imem_data2_i = $urandom;
    end
    stray = 0;
    #1;
    redir = flush_en_i | branch_en_i | jump_en_i;
    tgt = flush_en_i ? flush_PC_i : (branch_en_i ? branch_PC_i : jump_PC_i);
    tgt[1:0] = 2'b00;
    exp_req = !rst && !redir && !outst && (mq.size() < DEPTH);
    chk("req", imem_req_o, exp_req);
    chk("addr", imem_addr_o, exp_req ? next_fetch : 32'h0);
    chk("v1", ins1_valid_o, exp_v);
    chk("v2", ins2_valid_o, exp_v);
    chk("pc1", PC1_o, exp_pc1);
    chk("pc2", PC2_o, exp_pc2);
    chk("ins1", instruction1_o, exp_i1);
    chk("ins2", instruction2_o, exp_i2);
    last_req = imem_req_o; last_addr = imem_addr_o;
    last_v = ins1_valid_o; last_pc1 = PC1_o; last_pc2 = PC2_o;

    if (rst) begin
      model_reset();
    end else begin
      accept = mem_fire && !stale && !redir;
      if (mem_fire) begin outst = 0; stale = 0; end
      else if (outst && redir) stale = 1;
      if (redir) begin
        mq.delete();
        exp_v = 0;
        next_fetch = tgt;
      end else begin
        if (mq.size() > 0 && !ROB_full_i) begin
          p = mq.pop_front();
          exp_v = 1; exp_pc1 = p; exp_pc2 = p + 4;
          exp_i1 = mem_word(p); exp_i2 = mem_word(p + 4);
        end else begin
          exp_v = 0;
        end
        if (accept) begin
          mq.push_back(outst_addr);
          next_fetch = next_fetch + 8;
        end
      end
      if (imem_req_o === 1'b1) begin
        outst = 1; stale = 0; outst_addr = imem_addr_o;
        wait_cnt = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1; ROB_full_i = 0; stray = 0; mem_lat = 1;
    jump_en_i = 0; branch_en_i = 0; flush_en_i = 0;
    jump_PC_i = 0; branch_PC_i = 0; flush_PC_i = 0;
    imem_valid_i = 0; imem_data1_i = 0; imem_data2_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (2) step();

    // Cold start with 1-cycle memory
    rst = 0;
    step(); chk("cold_req_c0", last_req, 1); chk("cold_addr_c0", last_addr, 32'h100);
    step();
    step(); chk("cold_req_c2", last_req, 1); chk("cold_addr_c2", last_addr, 32'h108);
    step(); chk("cold_v_c3", last_v, 1); chk("cold_pc1_c3", last_pc1, 32'h100); chk("cold_pc2_c3", last_pc2, 32'h104);
    step(); chk("cold_req_c4", last_req, 1); chk("cold_addr_c4", last_addr, 32'h110);
    step(); chk("cold_v_c5", last_v, 1); chk("cold_pc1_c5", last_pc1, 32'h108);

    // Backpressure fills the queue, release drains 4 pairs back to back
    ROB_full_i = 1;
    repeat (20) step();
    chk("bp_req_stopped", last_req, 0); chk("bp_v_low", last_v, 0);
    ROB_full_i = 0;
    step(); chk("bp_release_v", last_v, 0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("bp_drain_v", last_v, 1);
    end

    // Empty queue via jump, fill to 3 pairs, then branch while IDLE
    jump_en_i = 1; jump_PC_i = 32'h3000; step(); jump_en_i = 0;
    ROB_full_i = 1;
    n = 0;
    while (!(mq.size() == 3 && !outst) && n < 40) begin step(); n++; end
    chk("br_fill_timeout", (n < 40) ? 1 : 0, 1);
    branch_en_i = 1; branch_PC_i = 32'h2002; ROB_full_i = 0;
    step(); branch_en_i = 0;
    step(); chk("br_req", last_req, 1); chk("br_addr", last_addr, 32'h2000); chk("br_v_cleared", last_v, 0);
    n = 0;
    while (last_v !== 1'b1 && n < 10) begin step(); n++; end
    chk("br_first_pc1", last_pc1, 32'h2000);

    // Flush while WAIT, response 3 cycles after the flush
    mem_lat = 4;
    n = 0;
    while (last_req !== 1'b1 && n < 10) begin step(); n++; end
    flush_en_i = 1; flush_PC_i = 32'h400; step(); flush_en_i = 0;
    n = 0;
    do begin step(); n++; end while (last_req !== 1'b1 && n < 10);
    chk("drop_req_addr", last_addr, 32'h400);
    chk("drop_cycles", n, 4);

    // All three redirects together with a memory response
    mem_lat = 2;
    n = 0;
    do begin step(); n++; end while (last_req !== 1'b1 && n < 10);
    step();
    flush_en_i = 1; flush_PC_i = 32'h500;
    branch_en_i = 1; branch_PC_i = 32'h600;
    jump_en_i = 1; jump_PC_i = 32'h700;
    step();
    chk("sim_resp_fired", mem_fire, 1);
    flush_en_i = 0; branch_en_i = 0; jump_en_i = 0;
    step(); chk("sim_req", last_req, 1); chk("sim_addr", last_addr, 32'h500);

    // Reset in WAIT with two queued pairs; a stray response afterwards is ignored
    mem_lat = 3; ROB_full_i = 1;
    n = 0;
    while (!(mq.size() == 2 && outst) && n < 40) begin step(); n++; end
    chk("rst_fill_timeout", (n < 40) ? 1 : 0, 1);
    rst = 1; ROB_full_i = 0;
    step();
    rst = 0; stray = 1;
    step(); chk("mrst_v", last_v, 0); chk("mrst_req", last_req, 1); chk("mrst_addr", last_addr, RST_PC);
    repeat (8) step();

    // Randomized traffic against the model
    mem_lat = 0;
    for (int i = 0; i < 1500; i++) begin
      ROB_full_i  = ($urandom_range(0, 9) < 3);
      flush_en_i  = ($urandom_range(0, 49) == 0);
      branch_en_i = ($urandom_range(0, 39) == 0);
      jump_en_i   = ($urandom_range(0, 39) == 0);
      flush_PC_i  = $urandom;
      branch_PC_i = $urandom;
      jump_PC_i   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF1 : $urandom;
      rst         = ($urandom_range(0, 99) == 0);
      stray       = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 0; flush_en_i = 0; branch_en_i = 0; jump_en_i = 0; ROB_full_i = 0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
